// File: rtl/dmem_lsu.sv
// rtl/dmem_lsu.sv - data-memory load/store sequencer (initiator side of the data port)
//
// Accepts one word or byte load/store over a valid/ready handshake, drives the
// memory port for one or more beats, assembles load data and returns a
// one-cycle response.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/req_ready request handshake; req_we (store), req_byte (byte access),
//                       req_addr (byte address), req_wdata (store data, byte uses [7:0])
//   resp_valid          one-cycle completion pulse; resp_rdata load data (0 for
//                       stores), resp_err rejected request
//   mem_we/mem_be       memory write enable / byte-mode select
//   mem_a/mem_wd/mem_rd memory byte address, write data, read data
//
// Build option: DMEM_LSU_UNALIGNED_EN splits an unaligned word access into four
// byte beats; without it such a request is rejected with resp_err.

module dmem_lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_byte,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic        mem_be,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e      state_q, state_d;
  logic        ready_q, ready_d;
  logic        we_q, we_d;
  logic        bmode_q, bmode_d;   // beats are byte beats (byte access or split word)
  logic        multi_q, multi_d;   // four-beat split of an unaligned word
  logic        err_q, err_d;
  logic [1:0]  k_q, k_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic        unaligned;
  logic        last_beat;

  assign unaligned = !req_byte && (req_addr[1:0] != 2'b00);
  assign last_beat = !multi_q || (k_q == 2'd3);

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    bmode_d = bmode_q;
    multi_d = multi_q;
    err_d   = err_q;
    k_d     = k_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    asm_d   = asm_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          k_d     = 2'd0;
          asm_d   = 32'd0;
`ifdef DMEM_LSU_UNALIGNED_EN
          multi_d = unaligned;
          bmode_d = req_byte || unaligned;
          err_d   = 1'b0;
          state_d = ST_ACCESS;
`else
          multi_d = 1'b0;
          bmode_d = req_byte;
          err_d   = unaligned;
          state_d = unaligned ? ST_RESP : ST_ACCESS;
`endif
        end
      end
      ST_ACCESS: begin
        if (!we_q) begin
          // Split beats fill one byte lane each; single beats take the whole bus.
          if (multi_q) asm_d[{k_q, 3'b000} +: 8] = mem_rd[7:0];
          else         asm_d = mem_rd;
        end
        if (last_beat) state_d = ST_RESP;
        else           k_d = k_q + 2'd1;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // Registered ready: high exactly in IDLE cycles that follow a clock edge.
    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b0;
      we_q    <= 1'b0;
      bmode_q <= 1'b0;
      multi_q <= 1'b0;
      err_q   <= 1'b0;
      k_q     <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      asm_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      we_q    <= we_d;
      bmode_q <= bmode_d;
      multi_q <= multi_d;
      err_q   <= err_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      asm_q   <= asm_d;
    end
  end

  // Outputs depend only on registered state, never on req_* or mem_rd.
  always_comb begin
    req_ready  = ready_q;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'd0;
    mem_we     = 1'b0;
    mem_be     = 1'b0;
    mem_a      = 32'd0;
    mem_wd     = 32'd0;
    case (state_q)
      ST_ACCESS: begin
        mem_we = we_q;
        mem_be = bmode_q;
        if (bmode_q) begin
          mem_a  = addr_q + {30'd0, k_q};
          mem_wd = {24'd0, wdata_q[{k_q, 3'b000} +: 8]};
        end else begin
          mem_a  = addr_q;
          mem_wd = wdata_q;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (we_q || err_q) ? 32'd0 : asm_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// tb/tb_dmem_lsu.sv - self-checking bench for dmem_lsu with a byte-array reference model
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic        req_byte = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic        mem_be;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd = 32'd0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rv_count = 0;
  int acc_log[$];
  logic [31:0] last_rdata;
  logic        last_err;

`ifdef DMEM_LSU_UNALIGNED_EN
  localparam bit UNAL_EN = 1'b1;
`else
  localparam bit UNAL_EN = 1'b0;
`endif

  dmem_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_byte(req_byte),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_be(mem_be), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  // Memory device: writes on rising edge, read data updates on falling edge.
  logic [7:0] dev_mem [bit [31:0]];
  logic [7:0] ref_mem [bit [31:0]];

  function automatic logic [7:0] dev_rd(input bit [31:0] a);
    if (dev_mem.exists(a)) return dev_mem[a];
    return 8'h00;
  endfunction

  function automatic logic [7:0] ref_rd(input bit [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_be) dev_mem[mem_a] = mem_wd[7:0];
      else for (int i = 0; i < 4; i++) dev_mem[mem_a + i] = mem_wd[8*i +: 8];
    end
  end

  always @(negedge clk) begin
    if (mem_be) mem_rd = {24'd0, dev_rd(mem_a)};
    else mem_rd = {dev_rd(mem_a + 3), dev_rd(mem_a + 2), dev_rd(mem_a + 1), dev_rd(mem_a)};
  end

  always @(posedge clk) begin
    if (rst_n && req_valid && req_ready) acc_log.push_back(cyc);
    cyc = cyc + 1;
  end

  always @(negedge clk) if (resp_valid) rv_count = rv_count + 1;

  // One transaction, checking every cycle against the spec-level prediction.
  task automatic do_req(input bit we, input bit bt, input bit [31:0] addr,
                        input bit [31:0] wd, input string nm);
    bit unal, rej, split;
    int nb, n;
    logic [31:0] exp_rd;
    logic [67:0] got_b, exp_b;
    logic [35:0] got_r, exp_r;
    unal  = !bt && (addr[1:0] != 2'b00);
    rej   = unal && !UNAL_EN;
    split = unal && UNAL_EN;
    nb    = rej ? 0 : (split ? 4 : 1);
    exp_rd = 32'd0;
    if (!we && !rej) begin
      if (bt) exp_rd = {24'd0, ref_rd(addr)};
      else for (int i = 0; i < 4; i++) exp_rd[8*i +: 8] = ref_rd(addr + i);
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_byte = bt; req_addr = addr; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) begin
      tests++; fails++;
      $display("FAIL %s ready_timeout: req_ready=%b required 1", nm, req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    for (int b = 0; b < nb; b++) begin
      got_b = {mem_we, mem_be, mem_a, mem_wd, req_ready, resp_valid};
      if (bt || split)
        exp_b = {we, 1'b1, addr + b, 24'd0, wd[8*b +: 8], 1'b0, 1'b0};
      else
        exp_b = {we, 1'b0, addr, wd, 1'b0, 1'b0};
      tests++;
      if (got_b !== exp_b) begin
        fails++;
        $display("FAIL %s beat%0d {we,be,a,wd,rdy,rv}: got %h required %h", nm, b, got_b, exp_b);
      end
      @(negedge clk);
    end
    got_r = {resp_valid, resp_err, resp_rdata, mem_we, req_ready};
    exp_r = {1'b1, rej, exp_rd, 1'b0, 1'b0};
    tests++;
    if (got_r !== exp_r) begin
      fails++;
      $display("FAIL %s resp {rv,err,rdata,we,rdy}: got %h required %h", nm, got_r, exp_r);
    end
    last_rdata = resp_rdata;
    last_err   = resp_err;
    @(negedge clk);
    tests++;
    if ({resp_valid, req_ready, mem_we} !== 3'b010) begin
      fails++;
      $display("FAIL %s after_resp {rv,rdy,we}: got %b required 010", nm, {resp_valid, req_ready, mem_we});
    end
    if (we && !rej) begin
      if (bt) ref_mem[addr] = wd[7:0];
      else for (int i = 0; i < 4; i++) ref_mem[addr + i] = wd[8*i +: 8];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_be, mem_a, mem_wd} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got rdy=%b rv=%b err=%b rd=%h we=%b be=%b a=%h wd=%h required all 0",
               req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_be, mem_a, mem_wd);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready_after_release: got %b required 1", req_ready);
    end
  endtask

  task automatic test_directed();
    do_req(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, "word_store");
    do_req(1'b0, 1'b0, 32'h10, 32'h0, "word_load");
    tests++;
    if (last_rdata !== 32'hDEADBEEF) begin
      fails++; $display("FAIL word_load_value: got %h required deadbeef", last_rdata);
    end
    do_req(1'b1, 1'b1, 32'h13, 32'hFFFFFFA5, "byte_store");
    do_req(1'b0, 1'b1, 32'h13, 32'h0, "byte_load");
    tests++;
    if (last_rdata !== 32'h000000A5) begin
      fails++; $display("FAIL byte_load_value: got %h required 000000a5", last_rdata);
    end
    do_req(1'b0, 1'b0, 32'h10, 32'h0, "word_after_byte");
    tests++;
    if (last_rdata !== 32'hA5ADBEEF) begin
      fails++; $display("FAIL word_after_byte_value: got %h required a5adbeef", last_rdata);
    end
  endtask

  task automatic test_unaligned();
    do_req(1'b1, 1'b0, 32'h10, 32'h44332211, "setup_lo");
    do_req(1'b1, 1'b0, 32'h14, 32'h88776655, "setup_hi");
    do_req(1'b0, 1'b0, 32'h11, 32'h0, "unal_load");
    tests++;
    if ({last_err, last_rdata} !== (UNAL_EN ? {1'b0, 32'h55443322} : {1'b1, 32'h0})) begin
      fails++; $display("FAIL unal_load_value: got err=%b rdata=%h required build-specific", last_err, last_rdata);
    end
    do_req(1'b1, 1'b0, 32'hFFFFFFFE, 32'hCAFEF00D, "wrap_store");
    do_req(1'b1, 1'b0, 32'h12, 32'h0BADC0DE, "unal_store");
  endtask

  task automatic test_back_to_back();
    int n;
    acc_log.delete();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h40; req_wdata = 32'h13572468;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_we = 1'b0; req_wdata = 32'h0;   // next request presented and held
    ref_mem[32'h40] = 8'h68; ref_mem[32'h41] = 8'h24;
    ref_mem[32'h42] = 8'h57; ref_mem[32'h43] = 8'h13;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({resp_valid, resp_rdata} !== {1'b1, 32'h13572468}) begin
      fails++; $display("FAIL b2b_second_resp: got rv=%b rdata=%h required 1 13572468", resp_valid, resp_rdata);
    end
    @(negedge clk);
    tests++;
    if (acc_log.size() != 2 || (acc_log[1] - acc_log[0]) != 3) begin
      fails++; $display("FAIL b2b_acceptances: got count=%0d required 2 with gap 3", acc_log.size());
    end
  endtask

  task automatic test_reset_mid();
    bit [31:0] a;
    int rv0;
    a = UNAL_EN ? 32'h201 : 32'h204;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = a; req_wdata = 32'hA1B2C3D4;
    while (!req_ready) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    if (UNAL_EN) @(negedge clk);
    rv0 = rv_count;
    #1 rst_n = 1'b0;
    #1;
    tests++;
    if ({req_ready, resp_valid, resp_err, resp_rdata, mem_we, mem_be, mem_a, mem_wd} !== '0) begin
      fails++; $display("FAIL reset_mid_outputs: got we=%b a=%h rv=%b required all 0", mem_we, mem_a, resp_valid);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (req_ready !== 1'b1) begin
      fails++; $display("FAIL reset_mid_ready: got %b required 1", req_ready);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (rv_count != rv0) begin
      fails++; $display("FAIL reset_mid_no_resp: got %0d pulses required 0", rv_count - rv0);
    end
    if (UNAL_EN) ref_mem[a] = 8'hD4;   // only beat 0 completed
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (dev_rd(a + i) !== ref_rd(a + i)) begin
        fails++; $display("FAIL reset_mid_mem%0d: got %h required %h", i, dev_rd(a + i), ref_rd(a + i));
      end
    end
  endtask

  task automatic test_random();
    bit [31:0] a;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFFC + $urandom_range(0, 3);
      else a = 32'h100 + $urandom_range(0, 31);
      do_req($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, a, $urandom, "random");
    end
  endtask

  task automatic test_mem_image();
    int bad;
    bad = 0;
    foreach (ref_mem[k]) if (dev_rd(k) !== ref_mem[k]) bad++;
    foreach (dev_mem[k]) if (dev_mem[k] !== ref_rd(k)) bad++;
    tests++;
    if (bad != 0) begin
      fails++; $display("FAIL mem_image: got %0d differing bytes required 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_unaligned();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_mem_image();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
